mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the 8-bit data address bus of the 16-bit single-cycle CPU.
- Serves byte loads (LB) and byte stores (SB) that the CPU issues to the top of the address space, 0xFB–0xFF (offsets -5..-1 from R0).
- Provides a synchronized input pin, an input rising-edge counter, an LED register and a 16-bit square-wave (tone) generator.
- Sits beside data RAM; the CPU read mux selects RDATA whenever HIT is high.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on IN_PIN before use (minimum 2).
- PERIOD_RST, 16'h0000: tone period value loaded at reset.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- ADDR  input  8  CPU data byte address.
- WDATA  input  8  store data (low byte of the SB source register).
- WE  input  1  store strobe for the current cycle.
- RDATA  output  8  load data, combinational from ADDR and registered state.
- HIT  output  1  combinational; high when ADDR is in 0xFB..0xFF.
- IN_PIN  input  1  asynchronous external input.
- LED  output  8  LED register.
- TONE  output  1  square-wave output.

Behaviour:
- Address map:
  - 0xFB IN: read {7'b0, in_s}; writes ignored.
  - 0xFC LED: read/write.
  - 0xFD ECNT: read returns the 8-bit edge count; any write clears it to 0.
  - 0xFE PLO: read returns committed period[7:0]; a write loads the lo_shadow register only.
  - 0xFF PHI: read returns committed period[15:8]; a write commits period <= {WDATA, lo_shadow} and restarts the tone generator.
- HIT is 0 outside 0xFB..0xFF. RDATA is 8'h00 when HIT=0. Stores with HIT=0 are ignored.
- Reset (asynchronous) sets:
  - LED=0, ECNT=0, lo_shadow=0, period=PERIOD_RST, tone counter=0, TONE=0.
  - all synchronizer stages and the edge-detect register to 0.
  - Reset asserted mid-tone forces TONE low immediately, without waiting for a clock edge.
- Writes take effect at the posedge where WE=1. A read in the same cycle returns the old value (no write-through). A read in the next cycle returns the new value.
- Input path:
  - in_s is IN_PIN after SYNC_STAGES flops, so latency is SYNC_STAGES cycles.
  - A rising edge is detected when in_s=1 and the previous in_s=0; each edge increments ECNT by 1.
  - ECNT wraps from 0xFF to 0x00.
  - If an ECNT write and an edge occur in the same cycle, the clear wins and ECNT=0; that edge is not counted.
- Tone generator:
  - period==0: counter held at 0, TONE held at 0.
  - period==P>0: counter counts 0..P-1. When the counter equals P-1 it returns to 0 and TONE toggles. Output frequency is f_CLK/(2P); P=1 toggles every cycle.
  - A PHI commit sets the counter to 0 and TONE to 0 on the same edge, including when the new period equals the old one.
  - A PLO write alone never changes the running period.
- In the same cycle as a commit, the counter does not also advance, so there is no off-by-one after a commit.
- The CPU issues at most one store per cycle, so simultaneous writes to multiple registers cannot occur.

Test Plan:
1. Reset asserted asynchronously mid-cycle with TONE=1 and LED=0xA5 -> TONE=0 and LED=0x00 before the next CLK edge; reads of 0xFB..0xFF all return 0x00 (PERIOD_RST=0).
2. SB 0x03 to 0xFE, then SB 0x00 to 0xFF -> period=3. TONE rises 3 cycles after the commit edge and then toggles every 3 cycles (6-cycle period). LB 0xFE returns 0x03 and LB 0xFF returns 0x00. A later SB 0x09 to 0xFE alone leaves the waveform unchanged.
3. Apply 5 IN_PIN pulses, each 4 cycles high and 4 cycles low -> LB 0xFD=0x05 and LB 0xFB tracks the pin with a 2-cycle lag. Then 256 more pulses -> ECNT=0x05 (wrap). SB any value to 0xFD coinciding with an edge -> ECNT=0x00.
4. SB 0x5A to 0xFC -> LED=0x5A from the next edge. LB 0xFC in the store cycle returns the old value; the following cycle returns 0x5A.
5. ADDR=0xFA with WE=1 and WDATA=0xFF -> HIT=0, RDATA=0x00, no register changes. ADDR=0xFB with WE=1 -> IN is unaffected.
6. Program a 0x0000 period commit while the tone is running -> TONE=0 and the counter is held at 0 indefinitely.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Byte-wide MMIO responder at 0xFB..0xFF: synchronized input pin, rising-edge
// counter, LED register and a programmable square-wave tone generator.
module mmio_port_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] PERIOD_RST  = 16'h0000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    input  logic       WE,
    output logic [7:0] RDATA,
    output logic       HIT,
    input  logic       IN_PIN,
    output logic [7:0] LED,
    output logic       TONE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   in_s;
    logic                   in_prev;
    logic                   in_rise;
    logic [7:0]             led_q;
    logic [7:0]             ecnt;
    logic [7:0]             lo_shadow;
    logic [15:0]            period;
    logic [15:0]            tone_cnt;
    logic                   tone_q;
    logic                   wr_led;
    logic                   wr_ecnt;
    logic                   wr_plo;
    logic                   wr_phi;

    assign HIT     = (ADDR >= 8'hFB);
    assign wr_led  = WE && (ADDR == 8'hFC);
    assign wr_ecnt = WE && (ADDR == 8'hFD);
    assign wr_plo  = WE && (ADDR == 8'hFE);
    assign wr_phi  = WE && (ADDR == 8'hFF);

    assign in_s    = sync_q[SYNC_STAGES-1];
    assign in_rise = in_s && !in_prev;
    assign LED     = led_q;
    assign TONE    = tone_q;

    // Shift register: IN_PIN enters at bit 0, in_s is the oldest stage.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q  <= '0;
            in_prev <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], IN_PIN};
            in_prev <= in_s;
        end
    end

    // A clear in the same cycle as an edge discards that edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ecnt <= 8'h00;
        end else if (wr_ecnt) begin
            ecnt <= 8'h00;
        end else if (in_rise) begin
            ecnt <= ecnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            led_q     <= 8'h00;
            lo_shadow <= 8'h00;
        end else begin
            if (wr_led) led_q <= WDATA;
            if (wr_plo) lo_shadow <= WDATA;
        end
    end

    // A commit restarts the waveform and takes priority over counting.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            period   <= PERIOD_RST;
            tone_cnt <= 16'h0000;
            tone_q   <= 1'b0;
        end else if (wr_phi) begin
            period   <= {WDATA, lo_shadow};
            tone_cnt <= 16'h0000;
            tone_q   <= 1'b0;
        end else if (period == 16'h0000) begin
            tone_cnt <= 16'h0000;
            tone_q   <= 1'b0;
        end else if (tone_cnt == period - 16'd1) begin
            tone_cnt <= 16'h0000;
            tone_q   <= ~tone_q;
        end else begin
            tone_cnt <= tone_cnt + 16'd1;
        end
    end

    always_comb begin
        RDATA = 8'h00;
        case (ADDR)
            8'hFB:   RDATA = {7'b0, in_s};
            8'hFC:   RDATA = led_q;
            8'hFD:   RDATA = ecnt;
            8'hFE:   RDATA = period[7:0];
            8'hFF:   RDATA = period[15:8];
            default: RDATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: the driver queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mmio_port_responder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] ADDR = 8'h00;
    logic [7:0] WDATA = 8'h00;
    logic       WE = 1'b0;
    logic [7:0] RDATA;
    logic       HIT;
    logic       IN_PIN = 1'b0;
    logic [7:0] LED;
    logic       TONE;

    mmio_port_responder #(.SYNC_STAGES(2), .PERIOD_RST(16'h0000)) dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA), .WE(WE),
        .RDATA(RDATA), .HIT(HIT), .IN_PIN(IN_PIN), .LED(LED), .TONE(TONE)
    );

    always #5 CLK = ~CLK;

    localparam int K_RDATA = 0, K_HIT = 1, K_LED = 2, K_TONE = 3;

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic void push(int kind, logic [7:0] v, string n);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endfunction

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RDATA: act = RDATA;
                K_HIT:   act = {7'b0, HIT};
                K_LED:   act = LED;
                default: act = {7'b0, TONE};
            endcase
            nvec++;
            if (act !== e.exp) begin
                nmis++;
                $display("FAIL %s: got %02h expected %02h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ADDR = a; WDATA = d; WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] v, input string n);
        ADDR = a; WE = 1'b0;
        push(K_RDATA, v, n);
        cyc();
    endtask

    task automatic wait_tone_high(input string n);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (TONE === 1'b1) begin
                seen = 1;
                break;
            end
            cyc();
        end
        nvec++;
        if (!seen) begin
            nmis++;
            $display("FAIL %s: TONE never went high within 40 cycles", n);
        end
    endtask

    task automatic pulse();
        IN_PIN = 1'b1;
        repeat (4) cyc();
        IN_PIN = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        cyc(); cyc();
        RESET = 1'b0;

        // Post-reset reads and decode
        rd(8'hFB, 8'h00, "rst_in");
        rd(8'hFC, 8'h00, "rst_led");
        rd(8'hFD, 8'h00, "rst_ecnt");
        rd(8'hFE, 8'h00, "rst_plo");
        rd(8'hFF, 8'h00, "rst_phi");
        ADDR = 8'hFB; push(K_HIT, 8'h01, "hit_fb"); cyc();
        ADDR = 8'hFF; push(K_HIT, 8'h01, "hit_ff"); cyc();

        // LED store: old value in store cycle, new value after
        ADDR = 8'hFC; WDATA = 8'h5A; WE = 1'b1;
        push(K_RDATA, 8'h00, "led_same_cycle");
        cyc();
        WE = 1'b0;
        push(K_RDATA, 8'h5A, "led_next_cycle");
        push(K_LED, 8'h5A, "led_port");
        cyc();

        // Stores outside the window and to IN are ignored
        ADDR = 8'hFA; WDATA = 8'hFF; WE = 1'b1;
        push(K_HIT, 8'h00, "hit_fa");
        push(K_RDATA, 8'h00, "rdata_fa");
        cyc();
        ADDR = 8'hFB; WDATA = 8'hFF; WE = 1'b1;
        cyc();
        WE = 1'b0;
        rd(8'hFB, 8'h00, "in_after_wr");
        rd(8'hFC, 8'h5A, "led_after_miss");
        rd(8'hFD, 8'h00, "ecnt_after_miss");
        rd(8'hFE, 8'h00, "plo_after_miss");
        rd(8'hFF, 8'h00, "phi_after_miss");
        ADDR = 8'h00; push(K_LED, 8'h5A, "led_port_after_miss"); cyc();

        // Tone with period 3; PLO write alone must not disturb it
        wr(8'hFE, 8'h03);
        rd(8'hFE, 8'h00, "plo_before_commit");
        wr(8'hFF, 8'h00);
        for (int k = 0; k < 18; k++) begin
            if (k == 7) begin
                ADDR = 8'hFE; WDATA = 8'h09; WE = 1'b1;
            end else begin
                WE = 1'b0;
                ADDR = (k % 2 == 0) ? 8'hFE : 8'hFF;
            end
            push(K_TONE, ((k / 3) % 2 == 1) ? 8'h01 : 8'h00, $sformatf("tone_p3_k%0d", k));
            push(K_RDATA, (ADDR == 8'hFE) ? 8'h03 : 8'h00, $sformatf("period_rd_k%0d", k));
            cyc();
        end

        // Asynchronous reset mid-cycle with TONE high and LED=A5
        wr(8'hFC, 8'hA5);
        wait_tone_high("tone_before_reset");
        ADDR = 8'hFC;
        #2 RESET = 1'b1;
        push(K_TONE, 8'h00, "async_rst_tone");
        push(K_LED, 8'h00, "async_rst_led");
        push(K_RDATA, 8'h00, "async_rst_rdata");
        cyc();
        RESET = 1'b0;
        rd(8'hFB, 8'h00, "rst2_in");
        rd(8'hFC, 8'h00, "rst2_led");
        rd(8'hFD, 8'h00, "rst2_ecnt");
        rd(8'hFE, 8'h00, "rst2_plo");
        rd(8'hFF, 8'h00, "rst2_phi");
        for (int k = 0; k < 6; k++) begin
            push(K_TONE, 8'h00, "tone_idle_after_reset");
            cyc();
        end

        // Input path: 2-cycle lag on IN, edge counting, wrap
        ADDR = 8'hFB;
        for (int j = 0; j < 8; j++) begin
            IN_PIN = (j < 4);
            push(K_RDATA, (j >= 2 && j < 6) ? 8'h01 : 8'h00, $sformatf("in_lag_j%0d", j));
            cyc();
        end
        repeat (4) pulse();
        rd(8'hFD, 8'h05, "ecnt_5");
        repeat (256) pulse();
        rd(8'hFD, 8'h05, "ecnt_wrap");

        // Clear coinciding with an edge: clear wins, edge is dropped
        IN_PIN = 1'b1;
        cyc(); cyc();
        ADDR = 8'hFD; WDATA = 8'h77; WE = 1'b1;
        cyc();
        WE = 1'b0;
        rd(8'hFD, 8'h00, "ecnt_clear_edge");
        rd(8'hFD, 8'h00, "ecnt_clear_hold");
        IN_PIN = 1'b0;
        repeat (4) cyc();
        pulse();
        rd(8'hFD, 8'h01, "ecnt_after_clear");

        // Commit period 0 while tone is running
        wr(8'hFE, 8'h02);
        wr(8'hFF, 8'h00);
        wr(8'hFE, 8'h00);
        wait_tone_high("tone_before_zero");
        ADDR = 8'hFF; WDATA = 8'h00; WE = 1'b1;
        cyc();
        WE = 1'b0;
        ADDR = 8'hFE;
        for (int k = 0; k < 20; k++) begin
            push(K_TONE, 8'h00, $sformatf("tone_zero_k%0d", k));
            if (k == 0) push(K_RDATA, 8'h00, "plo_zero");
            cyc();
        end

        cyc();
        nvec++;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
